// File: rtl/cdb_arbiter.sv
// cdb_arbiter
// Result-bus arbiter between the execution units and writeback.
// Each source (ALU, store address unit, multiplier, load buffer) feeds a
// small FIFO. One queue head per cycle is granted round-robin onto the
// registered common data bus. A full queue back-pressures its source.
// Speculative entries are discarded on a branch misprediction (squash).
//
// Ports
//   clock      in   clock
//   reset      in   asynchronous, active-high reset
//   alu_in     in   ALU result            (source 0)
//   st_in      in   store address result  (source 1)
//   mult_in    in   multiplier result     (source 2)
//   ld_in      in   load buffer result    (source 3)
//   squash     in   misprediction: drop every spec=1 result this cycle
//   src_stall  out  per-source queue-full flag
//   cdb_out    out  registered CDB broadcast
//   cdb_src    out  source index of cdb_out (registered)

package cdb_pkg;
    typedef struct packed {
        logic        valid;
        logic [31:0] value;
        logic [5:0]  rob_tag;
        logic [31:0] inst;
        logic [31:0] npc;
        logic        spec;
    } EX_WR_PACKET;
endpackage

module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int QDEPTH = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  EX_WR_PACKET alu_in,
    input  EX_WR_PACKET st_in,
    input  EX_WR_PACKET mult_in,
    input  EX_WR_PACKET ld_in,
    input  logic        squash,
    output logic [3:0]  src_stall,
    output EX_WR_PACKET cdb_out,
    output logic [1:0]  cdb_src
);

    localparam int CW = $clog2(QDEPTH + 1);

    // Queue slot 0 is always the head; entries are kept packed toward it.
    EX_WR_PACKET   r_q    [4][QDEPTH];
    logic [CW-1:0] r_cnt  [4];
    logic [1:0]    r_rr;
    EX_WR_PACKET   r_cdb;
    logic [1:0]    r_src;

    EX_WR_PACKET   w_in   [4];
    logic [3:0]    w_push;
    logic          w_gnt_v;
    logic [1:0]    w_gnt;
    EX_WR_PACKET   w_head;
    EX_WR_PACKET   w_nq   [4][QDEPTH];
    logic [CW-1:0] w_ncnt [4];

    assign w_in[0] = alu_in;
    assign w_in[1] = st_in;
    assign w_in[2] = mult_in;
    assign w_in[3] = ld_in;

    assign cdb_out = r_cdb;
    assign cdb_src = r_src;

    always_comb begin
        src_stall = 4'b0000;
        w_push    = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            src_stall[i] = (r_cnt[i] == CW'(QDEPTH));
            w_push[i]    = w_in[i].valid && !src_stall[i] && !(squash && w_in[i].spec);
        end
    end

    // Round-robin search starting at r_rr. Walking the offsets from the far
    // end lets the nearest eligible queue overwrite the others.
    always_comb begin
        logic [1:0] idx;
        idx     = 2'd0;
        w_gnt_v = 1'b0;
        w_gnt   = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            idx = r_rr + 2'(k);
            if ((r_cnt[idx] != '0) && !(squash && r_q[idx][0].spec)) begin
                w_gnt_v = 1'b1;
                w_gnt   = idx;
            end
        end
    end

    always_comb begin
        w_head       = r_q[w_gnt][0];
        w_head.valid = 1'b1;
    end

    // Next queue image: drop the granted head and any squashed entries,
    // compact the survivors in order, then append the accepted push.
    always_comb begin
        int k;
        k = 0;
        for (int i = 0; i < 4; i++) begin
            k = 0;
            for (int m = 0; m < QDEPTH; m++) begin
                w_nq[i][m] = '0;
            end
            for (int j = 0; j < QDEPTH; j++) begin
                if ((j < int'(r_cnt[i])) &&
                    !(w_gnt_v && (int'(w_gnt) == i) && (j == 0)) &&
                    !(squash && r_q[i][j].spec)) begin
                    for (int m = 0; m < QDEPTH; m++) begin
                        if (m == k) begin
                            w_nq[i][m] = r_q[i][j];
                        end
                    end
                    k++;
                end
            end
            if (w_push[i]) begin
                for (int m = 0; m < QDEPTH; m++) begin
                    if (m == k) begin
                        w_nq[i][m] = w_in[i];
                    end
                end
                k++;
            end
            w_ncnt[i] = CW'(k);
        end
    end

    // Payload storage needs no reset: a zero count marks every slot empty.
    always_ff @(posedge clock) begin
        r_q <= w_nq;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt <= '{default: '0};
            r_rr  <= 2'd0;
            r_cdb <= '0;
            r_src <= 2'd0;
        end else begin
            r_cnt <= w_ncnt;
            if (w_gnt_v) begin
                r_cdb <= w_head;
                r_src <= w_gnt;
                r_rr  <= w_gnt + 2'd1;
            end else begin
                r_cdb <= '0;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Testbench for cdb_arbiter: table of per-cycle vectors against a QDEPTH=2
// instance, plus hand-written sequences for squash (QDEPTH=3 instance) and
// asynchronous reset in the middle of operation.

module tb_cdb_arbiter;
    import cdb_pkg::*;

    logic        clock;
    logic        reset;
    EX_WR_PACKET alu_in, st_in, mult_in, ld_in;
    logic        squash;

    logic [3:0]  c2_stall, c3_stall;
    EX_WR_PACKET c2_out, c3_out;
    logic [1:0]  c2_src, c3_src;

    int n_vec = 0;
    int n_err = 0;

    cdb_arbiter #(.QDEPTH(2)) dut2 (
        .clock(clock), .reset(reset),
        .alu_in(alu_in), .st_in(st_in), .mult_in(mult_in), .ld_in(ld_in),
        .squash(squash),
        .src_stall(c2_stall), .cdb_out(c2_out), .cdb_src(c2_src)
    );

    cdb_arbiter #(.QDEPTH(3)) dut3 (
        .clock(clock), .reset(reset),
        .alu_in(alu_in), .st_in(st_in), .mult_in(mult_in), .ld_in(ld_in),
        .squash(squash),
        .src_stall(c3_stall), .cdb_out(c3_out), .cdb_src(c3_src)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0]      vld;
        logic [3:0][5:0] tag;
        logic            ev;
        logic [5:0]      etag;
        logic [1:0]      esrc;
        logic [3:0]      estall;
    } vec_t;

    vec_t tbl[$];

    function automatic EX_WR_PACKET mk(input int tag, input logic spec);
        EX_WR_PACKET p;
        p.valid   = 1'b1;
        p.value   = 32'h0000_122F + 32'(tag);
        p.rob_tag = 6'(tag);
        p.inst    = 32'hDEAD_BEEF ^ 32'(tag);
        p.npc     = 32'h0000_0400 + 32'(tag * 4);
        p.spec    = spec;
        return p;
    endfunction

    task automatic add(input int vld, input int t0, input int t1, input int t2, input int t3,
                       input int ev, input int etag, input int esrc, input int estall);
        vec_t v;
        v.vld    = 4'(vld);
        v.tag[0] = 6'(t0);
        v.tag[1] = 6'(t1);
        v.tag[2] = 6'(t2);
        v.tag[3] = 6'(t3);
        v.ev     = 1'(ev);
        v.etag   = 6'(etag);
        v.esrc   = 2'(esrc);
        v.estall = 4'(estall);
        tbl.push_back(v);
    endtask

    task automatic drv(input logic [3:0] vld, input int t0, input int t1, input int t2,
                       input int t3, input logic [3:0] sp, input logic sq);
        alu_in  = vld[0] ? mk(t0, sp[0]) : '0;
        st_in   = vld[1] ? mk(t1, sp[1]) : '0;
        mult_in = vld[2] ? mk(t2, sp[2]) : '0;
        ld_in   = vld[3] ? mk(t3, sp[3]) : '0;
        squash  = sq;
    endtask

    task automatic idle();
        drv(4'b0000, 0, 0, 0, 0, 4'b0000, 1'b0);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_pkt(input string nm, input EX_WR_PACKET act, input EX_WR_PACKET exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got v=%0b tag=%0d val=%h spec=%0b (%h), want v=%0b tag=%0d val=%h spec=%0b (%h)",
                     nm, act.valid, act.rob_tag, act.value, act.spec, act,
                     exp.valid, exp.rob_tag, exp.value, exp.spec, exp);
        end
    endtask

    task automatic chk_val(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic chk3(input string nm, input int etag, input logic espec, input logic ev,
                        input int esrc, input int estall);
        chk_pkt({nm, " q3 cdb_out"}, c3_out, ev ? mk(etag, espec) : EX_WR_PACKET'('0));
        chk_val({nm, " q3 cdb_src"}, int'(c3_src), esrc);
        chk_val({nm, " q3 stall"}, int'(c3_stall), estall);
    endtask

    initial begin
        vec_t v;

        // Round-robin from reset pointer 0.
        add('b1111,  1,  2,  3,  4,  0,  0, 0, 'b0000);
        add('b0000,  0,  0,  0,  0,  1,  1, 0, 'b0000);
        add('b0000,  0,  0,  0,  0,  1,  2, 1, 'b0000);
        add('b0000,  0,  0,  0,  0,  1,  3, 2, 'b0000);
        add('b0000,  0,  0,  0,  0,  1,  4, 3, 'b0000);
        add('b0000,  0,  0,  0,  0,  0,  0, 3, 'b0000);
        // Single source, one-cycle pulse: visible two edges later for one cycle.
        add('b0001,  5,  0,  0,  0,  0,  0, 3, 'b0000);
        add('b0000,  0,  0,  0,  0,  1,  5, 0, 'b0000);
        add('b0000,  0,  0,  0,  0,  0,  0, 0, 'b0000);
        // Move pointer to 2, then all four again: order 3,4,1,2.
        add('b0010,  0,  6,  0,  0,  0,  0, 0, 'b0000);
        add('b0000,  0,  0,  0,  0,  1,  6, 1, 'b0000);
        add('b1111, 11, 12, 13, 14,  0,  0, 1, 'b0000);
        add('b0000,  0,  0,  0,  0,  1, 13, 2, 'b0000);
        add('b0000,  0,  0,  0,  0,  1, 14, 3, 'b0000);
        add('b0000,  0,  0,  0,  0,  1, 11, 0, 'b0000);
        add('b0000,  0,  0,  0,  0,  1, 12, 1, 'b0000);
        add('b0000,  0,  0,  0,  0,  0,  0, 1, 'b0000);
        // Multiplier back-pressure: tag 42 held while stalled, delivered once.
        add('b1011, 31, 32,  0, 34,  0,  0, 1, 'b0000);
        add('b0100,  0,  0, 40,  0,  1, 34, 3, 'b0000);
        add('b0100,  0,  0, 41,  0,  1, 31, 0, 'b0100);
        add('b0100,  0,  0, 42,  0,  1, 32, 1, 'b0100);
        add('b0100,  0,  0, 42,  0,  1, 40, 2, 'b0000);
        add('b0100,  0,  0, 42,  0,  1, 41, 2, 'b0000);
        add('b0000,  0,  0,  0,  0,  1, 42, 2, 'b0000);
        add('b0000,  0,  0,  0,  0,  0,  0, 2, 'b0000);
        // Full queue granted while its source is valid (ALU and store ping-pong).
        add('b0011, 50, 60,  0,  0,  0,  0, 2, 'b0000);
        add('b0011, 51, 61,  0,  0,  1, 50, 0, 'b0010);
        add('b0011, 52, 62,  0,  0,  1, 60, 1, 'b0001);
        add('b0011, 53, 62,  0,  0,  1, 51, 0, 'b0010);
        add('b0011, 53, 63,  0,  0,  1, 61, 1, 'b0001);
        add('b0010,  0, 63,  0,  0,  1, 52, 0, 'b0010);
        add('b0000,  0,  0,  0,  0,  1, 62, 1, 'b0000);
        add('b0000,  0,  0,  0,  0,  1, 53, 0, 'b0000);
        add('b0000,  0,  0,  0,  0,  1, 63, 1, 'b0000);
        add('b0000,  0,  0,  0,  0,  0,  0, 1, 'b0000);

        reset = 1'b1;
        idle();
        #12;
        chk_pkt("reset cdb_out", c2_out, '0);
        chk_val("reset cdb_src", int'(c2_src), 0);
        chk_val("reset stall", int'(c2_stall), 0);
        chk_pkt("reset q3 cdb_out", c3_out, '0);
        step();
        reset = 1'b0;

        for (int n = 0; n < tbl.size(); n++) begin
            v = tbl[n];
            drv(v.vld, int'(v.tag[0]), int'(v.tag[1]), int'(v.tag[2]), int'(v.tag[3]),
                4'b0000, 1'b0);
            step();
            chk_pkt($sformatf("vec%0d cdb_out", n), c2_out,
                    v.ev ? mk(int'(v.etag), 1'b0) : EX_WR_PACKET'('0));
            chk_val($sformatf("vec%0d cdb_src", n), int'(c2_src), int'(v.esrc));
            chk_val($sformatf("vec%0d stall", n), int'(c2_stall), int'(v.estall));
        end

        // Squash on the QDEPTH=3 instance: load queue holds 7, 8(spec), 9.
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
        drv(4'b1111, 70, 71, 72, 7, 4'b0000, 1'b0); step(); chk3("sq0", 0, 1'b0, 1'b0, 0, 'b0000);
        drv(4'b1000, 0, 0, 0, 8, 4'b1000, 1'b0);    step(); chk3("sq1", 70, 1'b0, 1'b1, 0, 'b0000);
        drv(4'b1000, 0, 0, 0, 9, 4'b0000, 1'b0);    step(); chk3("sq2", 71, 1'b0, 1'b1, 1, 'b1000);
        drv(4'b1000, 0, 0, 0, 10, 4'b1000, 1'b1);   step(); chk3("sq3", 72, 1'b0, 1'b1, 2, 'b0000);
        idle();                                     step(); chk3("sq4", 7, 1'b0, 1'b1, 3, 'b0000);
        idle();                                     step(); chk3("sq5", 9, 1'b0, 1'b1, 3, 'b0000);
        idle();                                     step(); chk3("sq6", 0, 1'b0, 1'b0, 3, 'b0000);
        // Speculative head under squash is neither granted nor kept.
        drv(4'b1000, 0, 0, 0, 80, 4'b1000, 1'b0);   step(); chk3("sq7", 0, 1'b0, 1'b0, 3, 'b0000);
        drv(4'b0000, 0, 0, 0, 0, 4'b0000, 1'b1);    step(); chk3("sq8", 0, 1'b0, 1'b0, 3, 'b0000);
        idle();                                     step(); chk3("sq9", 0, 1'b0, 1'b0, 3, 'b0000);
        // Without squash a spec=1 result passes through with its spec bit.
        drv(4'b0001, 81, 0, 0, 0, 4'b0001, 1'b0);   step(); chk3("sq10", 0, 1'b0, 1'b0, 3, 'b0000);
        idle();                                     step(); chk3("sq11", 81, 1'b1, 1'b1, 0, 'b0000);

        // Asynchronous reset with three queues full and a valid broadcast.
        reset = 1'b1;
        step();
        reset = 1'b0;
        drv(4'b1111, 91, 92, 93, 94, 4'b0000, 1'b0); step();
        drv(4'b1111, 95, 96, 97, 98, 4'b0000, 1'b0); step();
        chk_pkt("pre-reset cdb_out", c2_out, mk(91, 1'b0));
        chk_val("pre-reset stall", int'(c2_stall), 'b1110);
        idle();
        #2;
        reset = 1'b1;
        #1;
        chk_pkt("async reset cdb_out", c2_out, '0);
        chk_val("async reset cdb_src", int'(c2_src), 0);
        chk_val("async reset stall", int'(c2_stall), 0);
        step();
        reset = 1'b0;
        for (int n = 0; n < 4; n++) begin
            step();
            chk_pkt($sformatf("post-reset%0d cdb_out", n), c2_out, '0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
